instr_loader: RTL and testbench

Byte-stream program loader for the single-cycle MIPS core. It receives a length-prefixed stream of big-endian instruction bytes over a valid/ready handshake and assembles 32-bit instruction words. It writes those words into instruction memory from word address 0 and holds the CPU (`cpu_hold`) for the duration of the load. It is the writer of the instruction words whose op/funct fields the control decoder consumes.

---
 rtl/instr_loader.sv | 126 ++++++++++++
 tb/tb_instr_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Program loader: receives a length-prefixed big-endian byte stream and writes
// 32-bit instruction words into instruction memory from address 0, holding the CPU meanwhile.
module instr_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [15:0] idx;
    logic [1:0]  byte_cnt;
    logic [23:0] word_acc;
    logic        hold_q;
    logic        err_q;
    logic        rdy_st;
    logic        xfer;
    logic [15:0] len_next;
    logic        len_bad;

    // Ready depends on the state register alone, never on in_valid.
    assign rdy_st   = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
    assign xfer     = in_valid & rdy_st;
    assign len_next = {len_hi, in_data};
    assign len_bad  = (len_next == 16'd0) || ({1'b0, len_next} > CAPACITY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            hold_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                hold_q <= 1'b1;
                err_q  <= 1'b0;
            end
            if (state == S_LEN_LO && xfer && len_bad) begin
                err_q <= 1'b1;
            end
            // Hold is released only by a successful load; errors leave it set.
            if (state == S_DONE) begin
                hold_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = rdy_st;
        busy      = rdy_st || (state == S_WRITE);
        imem_we   = (state == S_WRITE);
        done      = (state == S_DONE);
        cpu_hold  = hold_q && (state != S_DONE);
        err       = err_q;
        unique case (state)
            S_IDLE:   if (start) state_nxt = S_LEN_HI;
            S_LEN_HI: if (xfer) state_nxt = S_LEN_LO;
            S_LEN_LO: if (xfer) state_nxt = len_bad ? S_ERR : S_DATA;
            S_DATA:   if (xfer && byte_cnt == 2'd3) state_nxt = S_WRITE;
            S_WRITE:  state_nxt = (idx + 16'd1 == len) ? S_DONE : S_DATA;
            S_DONE:   state_nxt = S_IDLE;
            S_ERR:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // The 4th byte goes straight into imem_wd so the word is ready in WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_hi    <= 8'd0;
            len       <= 16'd0;
            idx       <= 16'd0;
            byte_cnt  <= 2'd0;
            word_acc  <= 24'd0;
            imem_addr <= '0;
            imem_wd   <= 32'd0;
        end else begin
            case (state)
                S_LEN_HI: if (xfer) len_hi <= in_data;
                S_LEN_LO: if (xfer) begin
                    len      <= len_next;
                    idx      <= 16'd0;
                    byte_cnt <= 2'd0;
                end
                S_DATA: if (xfer) begin
                    word_acc <= {word_acc[15:0], in_data};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        imem_wd   <= {word_acc, in_data};
                        imem_addr <= idx[ADDR_W-1:0];
                    end
                end
                S_WRITE: idx <= idx + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: two instances (ADDR_W=8 and 4) share one stream
// and are scored against a word-list / memory-array model of the load protocol.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;

    logic        rdy8, we8, hold8, busy8, done8, err8;
    logic [7:0]  addr8;
    logic [31:0] wd8;
    logic        rdy4, we4, hold4, busy4, done4, err4;
    logic [3:0]  addr4;
    logic [31:0] wd4;

    logic        o_rdy [2];
    logic        o_we [2];
    logic        o_hold [2];
    logic        o_busy [2];
    logic        o_done [2];
    logic        o_err [2];
    logic [7:0]  o_addr [2];
    logic [31:0] o_wd [2];

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          exp_n = 0;
    bit          gaps = 0;
    int          wr_cnt [2];
    int          hold_cnt [2];
    int          done_seen [2];
    int          done_rel [2];
    logic [31:0] words [16];
    logic [31:0] mem [2][256];

    instr_loader #(.ADDR_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy8), .imem_we(we8), .imem_addr(addr8), .imem_wd(wd8),
        .cpu_hold(hold8), .busy(busy8), .done(done8), .err(err8)
    );

    instr_loader #(.ADDR_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy4), .imem_we(we4), .imem_addr(addr4), .imem_wd(wd4),
        .cpu_hold(hold4), .busy(busy4), .done(done4), .err(err4)
    );

    assign o_rdy[0] = rdy8;   assign o_rdy[1] = rdy4;
    assign o_we[0] = we8;     assign o_we[1] = we4;
    assign o_hold[0] = hold8; assign o_hold[1] = hold4;
    assign o_busy[0] = busy8; assign o_busy[1] = busy4;
    assign o_done[0] = done8; assign o_done[1] = done4;
    assign o_err[0] = err8;   assign o_err[1] = err4;
    assign o_addr[0] = addr8; assign o_addr[1] = {4'd0, addr4};
    assign o_wd[0] = wd8;     assign o_wd[1] = wd4;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every write must be the next word of the program, in order.
    task automatic mon(input int i);
        if (o_we[i]) begin
            if (wr_cnt[i] < exp_n) begin
                chk("wr_addr", 32'(o_addr[i]), 32'(wr_cnt[i]));
                chk("wr_data", o_wd[i], words[wr_cnt[i]]);
            end else begin
                chk("extra_write", 32'(wr_cnt[i]), 32'(exp_n));
            end
            chk("rdy_in_write", 32'(o_rdy[i]), 32'd0);
            mem[i][o_addr[i]] = o_wd[i];
            wr_cnt[i]++;
        end
        if (o_hold[i]) hold_cnt[i]++;
        if (o_done[i]) begin
            done_seen[i]++;
            done_rel[i] = cyc - t0 + 1;
            chk("hold_at_done", 32'(o_hold[i]), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0);
            mon(1);
        end
    end

    task automatic chk_reset_vals(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_ctrl"}, {26'd0, o_rdy[i], o_we[i], o_hold[i], o_busy[i], o_done[i], o_err[i]}, 32'd0);
            chk({tag, "_addr"}, 32'(o_addr[i]), 32'd0);
            chk({tag, "_wd"}, o_wd[i], 32'd0);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the edge that took the byte.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 0;
        in_data = b;
        for (int c = 0; c < 100 && !ok; c++) begin
            in_valid = (gaps && $urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            ok = in_valid && rdy8;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("byte_accept", 32'd0, 32'd1);
    endtask

    task automatic do_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 2; i++) begin
            wr_cnt[i] = 0;
            hold_cnt[i] = 0;
            done_seen[i] = 0;
            done_rel[i] = 0;
            chk("start_err_clr", 32'(o_err[i]), 32'd0);
            chk("start_busy_hold_rdy", {29'd0, o_busy[i], o_hold[i], o_rdy[i]}, 32'd7);
        end
    endtask

    task automatic load(input int n, input bit gp, input bit pulse);
        exp_n = n;
        gaps = 0;
        do_start();
        gaps = gp;
        send_byte(8'(n >> 8));
        send_byte(8'(n));
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 4; b++) begin
                if (pulse && k == 1 && b == 2) start = 1'b1;
                send_byte(words[k][31-8*b -: 8]);
                start = 1'b0;
            end
        end
        for (int c = 0; c < 40 && done_seen[0] == 0; c++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 2; i++) begin
            chk("done_count", 32'(done_seen[i]), 32'd1);
            chk("write_count", 32'(wr_cnt[i]), 32'(n));
            chk("err_after_load", 32'(o_err[i]), 32'd0);
            chk("hold_after_load", 32'(o_hold[i]), 32'd0);
            if (!gp) begin
                chk("done_cycle", 32'(done_rel[i]), 32'(3 + 5 * n));
                chk("hold_cycles", 32'(hold_cnt[i]), 32'(2 + 5 * n));
            end
            for (int k = 0; k < n; k++) chk("mem_word", mem[i][k], words[k]);
        end
        gaps = 0;
    endtask

    task automatic load_err(input int n);
        exp_n = 0;
        gaps = 0;
        do_start();
        send_byte(8'(n >> 8));
        send_byte(8'(n));
        for (int i = 0; i < 2; i++) begin
            chk("err_set", 32'(o_err[i]), 32'd1);
            chk("err_hold", 32'(o_hold[i]), 32'd1);
            chk("err_not_busy", 32'(o_busy[i]), 32'd0);
        end
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("err_no_write", 32'(wr_cnt[i]), 32'd0);
            chk("err_sticky", 32'(o_err[i]), 32'd1);
            chk("err_hold_kept", 32'(o_hold[i]), 32'd1);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;

        words[0] = 32'h20080005;
        words[1] = 32'h01095020;
        load(2, 0, 0);
        load(2, 1, 0);

        load_err(0);
        load_err(32'h0101);
        words[0] = $urandom;
        load(1, 0, 0);

        for (int k = 0; k < 3; k++) words[k] = $urandom;
        load(3, 0, 1);

        // Reset in the middle of word 1, between clock edges.
        for (int k = 0; k < 3; k++) words[k] = $urandom;
        exp_n = 3;
        do_start();
        send_byte(8'd0);
        send_byte(8'd3);
        for (int b = 0; b < 4; b++) send_byte(words[0][31-8*b -: 8]);
        send_byte(words[1][31:24]);
        send_byte(words[1][23:16]);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        for (int i = 0; i < 2; i++) begin
            chk("rst_word0_kept", mem[i][0], words[0]);
            chk("rst_writes", 32'(wr_cnt[i]), 32'd1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        words[0] = $urandom;
        load(1, 0, 0);

        for (int k = 0; k < 16; k++) words[k] = 32'(k);
        load(16, 0, 0);

        n = $urandom_range(1, 16);
        for (int k = 0; k < 16; k++) words[k] = $urandom;
        load(n, 1, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
